// File: rtl/trace_pkg.sv
// Shared types and sizing helpers for the retire-trace capture buffer.
package trace_pkg;

    localparam int INSTR_W    = 32;
    localparam int REG_W      = 5;
    localparam int IMM_W      = 12;
    localparam int HDR_W      = INSTR_W + 3 * REG_W + IMM_W;
    localparam int TRACE_XLEN = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_ARMED,
        ST_POST,
        ST_FROZEN
    } trace_state_t;

    // Everything in a record except the XLEN-wide write-back value.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [REG_W-1:0]   rd;
        logic [REG_W-1:0]   rs1;
        logic [REG_W-1:0]   rs2;
        logic [IMM_W-1:0]   imm;
    } trace_hdr_t;

    typedef struct packed {
        trace_hdr_t            hdr;
        logic [TRACE_XLEN-1:0] rd_value;
    } trace_rec_t;

    function automatic int rec_w(input int xlen);
        return HDR_W + xlen;
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int REC_W_DEFAULT = rec_w(TRACE_XLEN);

endpackage

// File: rtl/trace_ram.sv
// Entry store: one synchronous write port, one asynchronous read port.
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 107,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset; validity is tracked by the pointers and
    // count in the parent, so resetting it would only cost a reset tree.
    // NOTE: state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/trace_buffer.sv
// Retire-trace capture buffer: FIFO/ring store with mask/match trigger and
// post-trigger freeze, drained through a valid/ready stream.
module trace_buffer
    import trace_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int TS_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    trace_valid,
    input  logic [31:0]             trace_instruction,
    input  logic [4:0]              trace_rd,
    input  logic [4:0]              trace_rs1,
    input  logic [4:0]              trace_rs2,
    input  logic [11:0]             trace_imm,
    input  logic [XLEN-1:0]         trace_rd_value,
    input  logic                    cfg_enable,
    input  logic                    cfg_ring,
    input  logic                    cfg_trig_en,
    input  logic [31:0]             cfg_trig_match,
    input  logic [31:0]             cfg_trig_mask,
    input  logic [$clog2(DEPTH):0]  cfg_post_count,
    input  logic                    clear,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [HDR_W+XLEN-1:0]   out_data,
    output logic [TS_W-1:0]         out_ts,
    output logic [$clog2(DEPTH):0]  count,
    output logic [15:0]             overflow_cnt,
    output logic                    triggered,
    output logic                    frozen
);

    localparam int REC_W = rec_w(XLEN);
    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = REC_W + TS_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    trace_state_t     state, state_nxt;
    logic [CNT_W-1:0] remain, remain_nxt;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [TS_W-1:0]  ts;
    trace_hdr_t       hdr;
    logic [ENT_W-1:0] wr_entry, rd_entry;

    logic capturing, push, pop, full, ring_mode;
    logic overrun, overwrite, wr_en, trig_hit;

    // Armed and post-trigger capture always keep the newest history.
    assign capturing = cfg_enable && (state == ST_CAPTURE || state == ST_ARMED || state == ST_POST);
    assign ring_mode = cfg_ring || state == ST_ARMED || state == ST_POST;
    assign push      = capturing && trace_valid;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign full      = (count == FULL_CNT);
    assign overrun   = push && full && !pop;
    assign overwrite = overrun && ring_mode;
    assign wr_en     = push && !(overrun && !ring_mode);
    assign trig_hit  = (state == ST_ARMED) && push &&
                       ((trace_instruction & cfg_trig_mask) == (cfg_trig_match & cfg_trig_mask));

    assign hdr = '{instr: trace_instruction, rd: trace_rd, rs1: trace_rs1,
                   rs2: trace_rs2, imm: trace_imm};
    assign wr_entry = {hdr, trace_rd_value, ts};

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W),
        .AW    (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en && !clear && !rst),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    assign out_data = out_valid ? rd_entry[ENT_W-1 -: REC_W] : '0;
    assign out_ts   = out_valid ? rd_entry[TS_W-1:0] : '0;
    assign frozen   = (state == ST_FROZEN);

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt  = state;
        remain_nxt = remain;
        unique case (state)
            ST_IDLE: begin
                if (cfg_enable) begin
                    state_nxt = cfg_trig_en ? ST_ARMED : ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (!cfg_enable) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (!cfg_enable) begin
                    state_nxt = ST_IDLE;
                end else if (trig_hit) begin
                    remain_nxt = cfg_post_count;
                    state_nxt  = (cfg_post_count == '0) ? ST_FROZEN : ST_POST;
                end
            end
            ST_POST: begin
                if (!cfg_enable) begin
                    state_nxt = ST_IDLE;
                end else if (push) begin
                    remain_nxt = remain - CNT_W'(1);
                    if (remain == CNT_W'(1)) begin
                        state_nxt = ST_FROZEN;
                    end
                end
            end
            ST_FROZEN: begin
                state_nxt = ST_FROZEN;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (clear) begin
            state_nxt  = ST_IDLE;
            remain_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            remain <= '0;
        end else begin
            state  <= state_nxt;
            remain <= remain_nxt;
        end
    end

    // The timestamp ignores clear so captures on both sides of a flush
    // stay on one time base.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts <= '0;
        end else begin
            ts <= ts + TS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_cnt <= '0;
            triggered    <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop || overwrite) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (wr_en && !pop && !overwrite) begin
                count <= count + CNT_W'(1);
            end else if (pop && !wr_en) begin
                count <= count - CNT_W'(1);
            end
            if (overrun && overflow_cnt != 16'hFFFF) begin
                overflow_cnt <= overflow_cnt + 16'd1;
            end
            if (trig_hit) begin
                triggered <= 1'b1;
            end
        end
    end

endmodule
